ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver. It synchronises ps2_clk and ps2_data, assembles 11-bit frames and checks start, stop and odd parity. Good bytes are buffered in a FIFO and presented on a valid/ready interface. Adds error reporting, a mid-frame timeout and overflow detection, and sits between the board PS/2 pins and keyboard/scancode consumers.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_fifo.sv | 56 +++++
 rtl/ps2_rx_fifo.sv | 155 +++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions.
// Frame constants, receiver state type and parity helper.
package ps2_pkg;

  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_e;

  // True when data plus parity hold an odd number of ones.
  function automatic logic odd_parity_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous FIFO for received PS/2 bytes.
// A push into a full FIFO only lands when a pop frees a slot that cycle.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en;
  logic             rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (rd_en) rptr_q <= rptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with frame checks and a byte FIFO.
// Sticky error flags, mid-frame timeout and overflow detection.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic [7:0]                  data,
  output logic                        valid,
  input  logic                        ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        parity_err,
  output logic                        frame_err,
  input  logic                        clr_err
);

  localparam int          L        = SYNC_STAGES - 1;
  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);
  localparam logic [3:0]  PAR_BIT  = 4'(FRAME_BITS - 2);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  rx_state_e              state_q;
  logic [3:0]             bitcnt_q;
  logic [7:0]             shreg_q;
  logic                   par_q;
  logic [TW-1:0]          tcnt_q;
  logic                   overflow_q, overflow_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;

  logic sample;
  logic bit_in;
  logic frame_done;
  logic stop_bad;
  logic par_bad;
  logic push;
  logic pop;
  logic timeout;
  logic full;
  logic empty;

  // Index 0 is the newest sample; the top index is the oldest.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[L-1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[L-1:0], ps2_data};
    end
  end

  assign sample = clk_sync_q[L] & ~clk_sync_q[L-1];
  assign bit_in = dat_sync_q[L];

  assign frame_done = (state_q == RX_SHIFT) & sample
                    & (bitcnt_q == LAST_BIT);
  assign stop_bad   = frame_done & (bit_in != STOP_BIT);
  assign par_bad    = frame_done & ~stop_bad
                    & ~odd_parity_ok(shreg_q, par_q);
  assign push       = frame_done & ~stop_bad & ~par_bad;
  assign timeout    = (state_q == RX_SHIFT) & ~sample
                    & (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= RX_IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      unique case (state_q)
        RX_IDLE: begin
          tcnt_q <= '0;
          if (sample && bit_in == START_BIT) begin
            state_q  <= RX_SHIFT;
            bitcnt_q <= 4'd1;
          end
        end
        RX_SHIFT: begin
          if (sample) begin
            tcnt_q <= '0;
            if (bitcnt_q <= 4'd8) shreg_q <= {bit_in, shreg_q[7:1]};
            if (bitcnt_q == PAR_BIT) par_q <= bit_in;
            if (bitcnt_q == LAST_BIT) begin
              state_q  <= RX_IDLE;
              bitcnt_q <= '0;
            end else begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end
          end else if (timeout) begin
            state_q  <= RX_IDLE;
            bitcnt_q <= '0;
            tcnt_q   <= '0;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign pop = valid & ready;

  // New error events win over a same-cycle clear.
  always_comb begin
    overflow_d   = (overflow_q & ~clr_err) | (push & full & ~pop);
    parity_err_d = (parity_err_q & ~clr_err) | par_bad;
    frame_err_d  = (frame_err_q & ~clr_err) | stop_bad | timeout;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  ps2_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (push),
    .wdata_i (shreg_q),
    .pop_i   (pop),
    .rdata_o (data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign valid      = ~empty;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed scenarios plus random frames
// checked against a queue-based model of the receiver.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int TMO   = 10000;
  localparam int H     = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       parity_err;
  logic       frame_err;

  int passed = 0;
  int total  = 0;

  byte unsigned mq[$];
  bit mo, mp, mf;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (DEPTH),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .clr_err    (clr_err)
  );

  function automatic bit podd(input byte unsigned b);
    return ~^b;
  endfunction

  // Optionally pulse ready exactly in the cycle the stop bit is judged.
  task automatic drive_bits(input logic [10:0] bits, input int n,
                            input bit pop_at_eval);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (pop_at_eval && i == 10) begin
        repeat (SYNC - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (H - SYNC) @(posedge clk);
      end else begin
        repeat (H) @(posedge clk);
      end
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input byte unsigned b, input bit p, input bit stop,
                      input bit pop_at_eval);
    drive_bits({stop, p, b, 1'b0}, 11, pop_at_eval);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop1;
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic clr_flags;
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid);
    else passed++;
    total++;
    if (fifo_count !== 4'd0) $display("FAIL reset_count got %0d want 0", fifo_count);
    else passed++;
    total++;
    if ({overflow, parity_err, frame_err} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {overflow, parity_err, frame_err});
    else passed++;
    resetn = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic;
    send(8'h1C, 1'b0, 1'b1, 1'b0);
    total++;
    if (valid !== 1'b1) $display("FAIL basic_valid got %b want 1", valid);
    else passed++;
    total++;
    if (data !== 8'h1C) $display("FAIL basic_data got %h want 1c", data);
    else passed++;
    total++;
    if (fifo_count !== 4'd1) $display("FAIL basic_count got %0d want 1", fifo_count);
    else passed++;
    total++;
    if ({overflow, parity_err, frame_err} !== 3'b000)
      $display("FAIL basic_flags got %b want 000", {overflow, parity_err, frame_err});
    else passed++;
    pop1();
    total++;
    if (valid !== 1'b0 || fifo_count !== 4'd0)
      $display("FAIL basic_pop got valid=%b count=%0d want 0/0", valid, fifo_count);
    else passed++;
  endtask

  task automatic test_parity;
    send(8'h1C, 1'b1, 1'b1, 1'b0);
    total++;
    if (parity_err !== 1'b1) $display("FAIL par_flag got %b want 1", parity_err);
    else passed++;
    total++;
    if (fifo_count !== 4'd0) $display("FAIL par_count got %0d want 0", fifo_count);
    else passed++;
    clr_flags();
    total++;
    if (parity_err !== 1'b0) $display("FAIL par_clr got %b want 0", parity_err);
    else passed++;
    send(8'hF0, 1'b1, 1'b1, 1'b0);
    total++;
    if (valid !== 1'b1 || data !== 8'hF0)
      $display("FAIL par_next got valid=%b data=%h want 1/f0", valid, data);
    else passed++;
    pop1();
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 9; i++) send(8'(i), podd(8'(i)), 1'b1, 1'b0);
    total++;
    if (fifo_count !== 4'd8) $display("FAIL ovf_count got %0d want 8", fifo_count);
    else passed++;
    total++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow);
    else passed++;
    for (int i = 1; i <= 8; i++) begin
      total++;
      if (data !== 8'(i)) $display("FAIL ovf_order got %h want %h", data, 8'(i));
      else passed++;
      pop1();
    end
    total++;
    if (valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", valid);
    else passed++;
    clr_flags();
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 8; i++) send(8'(i), podd(8'(i)), 1'b1, 1'b0);
    send(8'h09, podd(8'h09), 1'b1, 1'b1);
    total++;
    if (fifo_count !== 4'd8) $display("FAIL b2b_count got %0d want 8", fifo_count);
    else passed++;
    total++;
    if (overflow !== 1'b0) $display("FAIL b2b_ovf got %b want 0", overflow);
    else passed++;
    for (int i = 2; i <= 9; i++) begin
      total++;
      if (data !== 8'(i)) $display("FAIL b2b_order got %h want %h", data, 8'(i));
      else passed++;
      pop1();
    end
  endtask

  task automatic test_timeout;
    drive_bits({1'b1, 1'b1, 8'hAA, 1'b0}, 5, 1'b0);
    repeat (TMO + 10) @(posedge clk);
    @(negedge clk);
    total++;
    if (frame_err !== 1'b1) $display("FAIL tmo_flag got %b want 1", frame_err);
    else passed++;
    total++;
    if (valid !== 1'b0 || fifo_count !== 4'd0)
      $display("FAIL tmo_push got valid=%b count=%0d want 0/0", valid, fifo_count);
    else passed++;
    clr_flags();
    send(8'hE0, 1'b0, 1'b1, 1'b0);
    total++;
    if (valid !== 1'b1 || data !== 8'hE0 || frame_err !== 1'b0)
      $display("FAIL tmo_next got valid=%b data=%h ferr=%b want 1/e0/0",
               valid, data, frame_err);
    else passed++;
    pop1();
  endtask

  task automatic test_stop_err;
    drive_bits(11'h7FF, 1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if ({overflow, parity_err, frame_err} !== 3'b000 || fifo_count !== 4'd0)
      $display("FAIL idle_one got flags=%b count=%0d want 000/0",
               {overflow, parity_err, frame_err}, fifo_count);
    else passed++;
    send(8'h55, 1'b1, 1'b0, 1'b0);
    total++;
    if (frame_err !== 1'b1 || parity_err !== 1'b0)
      $display("FAIL stop_flag got ferr=%b perr=%b want 1/0", frame_err, parity_err);
    else passed++;
    total++;
    if (fifo_count !== 4'd0) $display("FAIL stop_count got %0d want 0", fifo_count);
    else passed++;
    clr_flags();
  endtask

  task automatic test_mid_reset;
    send(8'h33, 1'b1, 1'b1, 1'b0);
    send(8'h33, 1'b0, 1'b1, 1'b0);
    drive_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6, 1'b0);
    #3 resetn = 1'b0;
    #1;
    total++;
    if ({valid, overflow, parity_err, frame_err} !== 4'b0000 || fifo_count !== 4'd0)
      $display("FAIL mrst_out got v/o/p/f=%b count=%0d want 0000/0",
               {valid, overflow, parity_err, frame_err}, fifo_count);
    else passed++;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    send(8'h1C, 1'b0, 1'b1, 1'b0);
    total++;
    if (valid !== 1'b1 || data !== 8'h1C || fifo_count !== 4'd1)
      $display("FAIL mrst_next got valid=%b data=%h count=%0d want 1/1c/1",
               valid, data, fifo_count);
    else passed++;
    pop1();
  endtask

  task automatic test_random;
    byte unsigned b;
    bit p, stop;
    int kind, npop;
    mq.delete();
    mo = 0; mp = 0; mf = 0;
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom);
      kind = $urandom_range(0, 7);
      stop = (kind != 1);
      p    = (kind == 0) ? ~podd(b) : (kind == 1 ? 1'($urandom) : podd(b));
      send(b, p, stop, 1'b0);
      if (!stop) mf = 1;
      else if ($countones({b, p}) % 2 == 0) mp = 1;
      else if (mq.size() < DEPTH) mq.push_back(b);
      else mo = 1;
      total++;
      if (fifo_count !== 4'(mq.size()) || valid !== (mq.size() != 0))
        $display("FAIL rnd_count got count=%0d valid=%b want %0d", fifo_count,
                 valid, mq.size());
      else passed++;
      total++;
      if ({overflow, parity_err, frame_err} !== {mo, mp, mf})
        $display("FAIL rnd_flags got %b want %b",
                 {overflow, parity_err, frame_err}, {mo, mp, mf});
      else passed++;
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop && mq.size() > 0; k++) begin
        total++;
        if (data !== mq[0]) $display("FAIL rnd_data got %h want %h", data, mq[0]);
        else passed++;
        pop1();
        void'(mq.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        clr_flags();
        mo = 0; mp = 0; mf = 0;
      end
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_stop_err();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
